patrol_sequencer: RTL and testbench

- Single-clock controller that sequences the robot's patrol cycle as a fixed order of one-cycle phase enables: sense -> decide -> act (turn / advance / remove) -> map update -> gap.
- Replaces free-running divided-clock phasing with explicit enables on the main clock.
- Samples the sensor-decision outputs (advance/turn/remove) and drives orientation, advance and map blocks.
- Tracks move count, detects "stuck" (too many consecutive turns) and supports start/halt from a supervisor.

---
 rtl/patrol_sequencer.sv | 173 +++++++++++++++++
 tb/tb_patrol_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/patrol_sequencer.sv
// patrol_sequencer: single-clock patrol phase controller.
// Runs the phases sense -> decide -> act (turn / move / clean) -> map -> gap
// as one-cycle enables on the main clock, and counts moves since the last start.
// It detects a stuck robot (too many turns in a row without a move) and accepts
// start/halt requests from a supervisor.
// Optional macro PATROL_STEP_LIMIT_EN: when defined, the patrol stops with
// done=1 once step_count reaches MAX_STEPS.
module patrol_sequencer #(
  parameter int PHASE_GAP     = 2,
  parameter int REMOVE_CYCLES = 3,
  parameter int MAX_TURNS     = 4,
  parameter int MAX_STEPS     = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        avancar,
  input  logic        girar,
  input  logic        remover,
  output logic        sense_en,
  output logic        turn_en,
  output logic        move_en,
  output logic        clean_active,
  output logic        map_en,
  output logic        busy,
  output logic        stuck,
  output logic        done,
  output logic [3:0]  state,
  output logic [15:0] step_count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SENSE  = 4'd1;
  localparam logic [3:0] S_DECIDE = 4'd2;
  localparam logic [3:0] S_TURN   = 4'd3;
  localparam logic [3:0] S_MOVE   = 4'd4;
  localparam logic [3:0] S_CLEAN  = 4'd5;
  localparam logic [3:0] S_MAP    = 4'd6;
  localparam logic [3:0] S_GAP    = 4'd7;
  localparam logic [3:0] S_STUCK  = 4'd8;

  localparam int TW = $clog2(MAX_TURNS + 1);
  localparam int CW = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
  localparam int GW = (PHASE_GAP > 1) ? $clog2(PHASE_GAP) : 1;

  localparam logic [TW-1:0] TURN_LIMIT = TW'(MAX_TURNS);
  localparam logic [CW-1:0] CLEAN_LOAD = CW'(REMOVE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'((PHASE_GAP > 0) ? PHASE_GAP - 1 : 0);

  logic [TW-1:0] turn_cnt;
  logic [CW-1:0] clean_cnt;
  logic [GW-1:0] gap_cnt;
  logic          halt_pend;
  logic          done_reg;

  // Main sequencer: state transitions plus every counter and flag they update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      step_count <= '0;
      turn_cnt   <= '0;
      clean_cnt  <= '0;
      gap_cnt    <= '0;
      halt_pend  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      // A halt seen mid-cycle is remembered here and honoured at the next MAP.
      // Later assignments below override it when the halt is acted on at once.
      if (halt_req && busy && (state != S_GAP))
        halt_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start && !halt_req) begin
            state      <= S_SENSE;
            step_count <= '0;
            turn_cnt   <= '0;
            halt_pend  <= 1'b0;
            done_reg   <= 1'b0;
          end
        end
        S_SENSE: state <= S_DECIDE;
        S_DECIDE: begin
          if (remover) begin
            state     <= S_CLEAN;
            clean_cnt <= CLEAN_LOAD;
          end else if (girar) begin
            state <= S_TURN;
          end else if (avancar) begin
            state <= S_MOVE;
          end else begin
            state <= S_MAP;
          end
        end
        S_TURN: begin
          if (turn_cnt != TURN_LIMIT)
            turn_cnt <= turn_cnt + 1'b1;
          state <= S_MAP;
        end
        S_MOVE: begin
          if (step_count != 16'hFFFF)
            step_count <= step_count + 16'd1;
          turn_cnt <= '0;
          state    <= S_MAP;
        end
        S_CLEAN: begin
          if (clean_cnt == '0)
            state <= S_MAP;
          else
            clean_cnt <= clean_cnt - 1'b1;
        end
        S_MAP: begin
          if (turn_cnt == TURN_LIMIT) begin
            state <= S_STUCK;
`ifdef PATROL_STEP_LIMIT_EN
          end else if (step_count == 16'(MAX_STEPS)) begin
            state     <= S_IDLE;
            done_reg  <= 1'b1;
            halt_pend <= 1'b0;
`endif
          end else if (halt_pend) begin
            state     <= S_IDLE;
            halt_pend <= 1'b0;
          end else if (PHASE_GAP == 0) begin
            state <= S_SENSE;
          end else begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (halt_req) begin
            state     <= S_IDLE;
            halt_pend <= 1'b0;
          end else if (gap_cnt == '0) begin
            state <= S_SENSE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_STUCK: begin
          if (halt_req) begin
            state <= S_IDLE;
          end else if (start) begin
            state      <= S_SENSE;
            step_count <= '0;
            turn_cnt   <= '0;
            halt_pend  <= 1'b0;
            done_reg   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches them combinationally.
  always_comb begin
    sense_en     = (state == S_SENSE);
    turn_en      = (state == S_TURN);
    move_en      = (state == S_MOVE);
    clean_active = (state == S_CLEAN);
    map_en       = (state == S_MAP);
    stuck        = (state == S_STUCK);
    busy         = (state != S_IDLE) && (state != S_STUCK);
`ifdef PATROL_STEP_LIMIT_EN
    done         = done_reg;
`else
    done         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_patrol_sequencer.sv
// tb_patrol_sequencer: directed self-checking bench for patrol_sequencer.
// Each scenario task drives stimulus and compares against hand-computed values.
// Optional macro PATROL_STEP_LIMIT_EN selects the expected step-limit behaviour.
module tb_patrol_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        avancar;
  logic        girar;
  logic        remover;
  logic        sense_en;
  logic        turn_en;
  logic        move_en;
  logic        clean_active;
  logic        map_en;
  logic        busy;
  logic        stuck;
  logic        done;
  logic [3:0]  state;
  logic [15:0] step_count;

  int errors = 0;
  int checks = 0;

  patrol_sequencer #(
    .PHASE_GAP(2),
    .REMOVE_CYCLES(3),
    .MAX_TURNS(4),
    .MAX_STEPS(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .halt_req(halt_req),
    .avancar(avancar),
    .girar(girar),
    .remover(remover),
    .sense_en(sense_en),
    .turn_en(turn_en),
    .move_en(move_en),
    .clean_active(clean_active),
    .map_en(map_en),
    .busy(busy),
    .stuck(stuck),
    .done(done),
    .state(state),
    .step_count(step_count)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    if (state !== 4'd0 || {sense_en, turn_en, move_en, clean_active, map_en, busy, stuck, done} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: state=%0d flags=%b expected state=0 flags=00000000", state,
               {sense_en, turn_en, move_en, clean_active, map_en, busy, stuck, done});
    end
    checks++;
    if (step_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_step_count: got %0d expected 0", step_count);
    end
    checks++;
    @(negedge clock);
    reset = 1'b1;
    tick();
    if (state !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_hold: state=%0d busy=%b expected 0/0", state, busy);
    end
    checks++;
  endtask

  task automatic test_move_timing();
    avancar = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (state !== 4'd1 || sense_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL move_c1_sense: state=%0d sense_en=%b busy=%b expected 1/1/1", state, sense_en, busy);
    end
    checks++;
    tick();
    if (state !== 4'd2 || sense_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL move_c2_decide: state=%0d sense_en=%b expected 2/0", state, sense_en);
    end
    checks++;
    tick();
    if (state !== 4'd4 || move_en !== 1'b1 || step_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL move_c3_move: state=%0d move_en=%b steps=%0d expected 4/1/0", state, move_en, step_count);
    end
    checks++;
    tick();
    if (state !== 4'd6 || map_en !== 1'b1 || move_en !== 1'b0 || step_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL move_c4_map: state=%0d map_en=%b move_en=%b steps=%0d expected 6/1/0/1", state, map_en, move_en,
               step_count);
    end
    checks++;
    tick();
    if (state !== 4'd7 || map_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL move_c5_gap: state=%0d map_en=%b expected 7/0", state, map_en);
    end
    checks++;
    tick();
    if (state !== 4'd7 || sense_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL move_c6_gap: state=%0d sense_en=%b expected 7/0", state, sense_en);
    end
    checks++;
    tick();
    if (state !== 4'd1 || sense_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL move_c7_period: state=%0d sense_en=%b expected 1/1", state, sense_en);
    end
    checks++;
  endtask

  task automatic test_halt();
    tick();
    tick();
    if (state !== 4'd4) begin
      errors++;
      $display("[TB] FAIL halt_in_move: state=%0d expected 4", state);
    end
    checks++;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    if (state !== 4'd6 || map_en !== 1'b1 || step_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL halt_map_kept: state=%0d map_en=%b steps=%0d expected 6/1/2", state, map_en, step_count);
    end
    checks++;
    tick();
    if (state !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_to_idle: state=%0d busy=%b expected 0/0", state, busy);
    end
    checks++;
    tick();
    if (state !== 4'd0 || sense_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_stays_idle: state=%0d sense_en=%b expected 0/0", state, sense_en);
    end
    checks++;
    start    = 1'b1;
    halt_req = 1'b1;
    tick();
    start    = 1'b0;
    halt_req = 1'b0;
    if (state !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_halt_idle: state=%0d busy=%b expected 0/0", state, busy);
    end
    checks++;
    tick();
    if (state !== 4'd0 || sense_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_halt_no_sense: state=%0d sense_en=%b expected 0/0", state, sense_en);
    end
    checks++;
    avancar = 1'b0;
  endtask

  task automatic test_clean();
    remover = 1'b1;
    girar   = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      remover = 1'b0;
      girar   = 1'b0;
      if (state !== 4'd5 || clean_active !== 1'b1 || turn_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clean_cycle%0d: state=%0d clean_active=%b turn_en=%b expected 5/1/0", i, state,
                 clean_active, turn_en);
      end
      checks++;
    end
    tick();
    if (state !== 4'd6 || map_en !== 1'b1 || clean_active !== 1'b0 || step_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL clean_then_map: state=%0d map_en=%b clean_active=%b steps=%0d expected 6/1/0/0", state,
               map_en, clean_active, step_count);
    end
    checks++;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    if (state !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_gap_halt: state=%0d busy=%b expected 0/0", state, busy);
    end
    checks++;
  endtask

  task automatic test_stuck();
    girar = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      if (state !== 4'd3 || turn_en !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stuck_turn%0d: state=%0d turn_en=%b expected 3/1", i, state, turn_en);
      end
      checks++;
      tick();
      if (state !== 4'd6 || map_en !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stuck_map%0d: state=%0d map_en=%b expected 6/1", i, state, map_en);
      end
      checks++;
      if (i < 3) begin
        tick();
        tick();
        tick();
        if (state !== 4'd1 || sense_en !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stuck_resense%0d: state=%0d sense_en=%b expected 1/1", i, state, sense_en);
        end
        checks++;
      end
    end
    tick();
    if (state !== 4'd8 || stuck !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stuck_entered: state=%0d stuck=%b busy=%b expected 8/1/0", state, stuck, busy);
    end
    checks++;
    tick();
    tick();
    if (state !== 4'd8 || stuck !== 1'b1 || sense_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stuck_hold: state=%0d stuck=%b sense_en=%b expected 8/1/0", state, stuck, sense_en);
    end
    checks++;
    girar = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (state !== 4'd1 || stuck !== 1'b0 || sense_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stuck_restart: state=%0d stuck=%b sense_en=%b expected 1/0/1", state, stuck, sense_en);
    end
    checks++;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    if (state !== 4'd6 || turn_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stuck_nodecision_map: state=%0d turn_en=%b expected 6/0", state, turn_en);
    end
    checks++;
    tick();
    if (state !== 4'd0) begin
      errors++;
      $display("[TB] FAIL stuck_halted: state=%0d expected 0", state);
    end
    checks++;
  endtask

  task automatic test_reset_mid_clean();
    avancar = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    avancar = 1'b0;
    remover = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    if (state !== 4'd5 || clean_active !== 1'b1 || step_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL rmc_in_clean: state=%0d clean_active=%b steps=%0d expected 5/1/1", state, clean_active,
               step_count);
    end
    checks++;
    #2;
    reset = 1'b0;
    #1;
    if (state !== 4'd0 || clean_active !== 1'b0 || step_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmc_async: state=%0d clean_active=%b steps=%0d busy=%b expected 0/0/0/0", state,
               clean_active, step_count, busy);
    end
    checks++;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (state !== 4'd0 || {sense_en, turn_en, move_en, clean_active, map_en} !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL rmc_quiet%0d: state=%0d pulses=%b expected 0/00000", i, state,
                 {sense_en, turn_en, move_en, clean_active, map_en});
      end
      checks++;
    end
    remover = 1'b0;
  endtask

  task automatic test_step_limit();
    avancar = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      tick();
      if (state !== 4'd6 || step_count !== 16'(i + 1) || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL limit_map%0d: state=%0d steps=%0d done=%b expected 6/%0d/0", i, state, step_count, done,
                 i + 1);
      end
      checks++;
      if (i < 2) begin
        tick();
        tick();
        tick();
      end
    end
    tick();
`ifdef PATROL_STEP_LIMIT_EN
    if (state !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL limit_done: state=%0d done=%b busy=%b expected 0/1/0", state, done, busy);
    end
    checks++;
    tick();
    if (state !== 4'd0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL limit_done_hold: state=%0d done=%b expected 0/1", state, done);
    end
    checks++;
    avancar = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (state !== 4'd1 || done !== 1'b0 || step_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL limit_restart: state=%0d done=%b steps=%0d expected 1/0/0", state, done, step_count);
    end
    checks++;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    tick();
    if (state !== 4'd0) begin
      errors++;
      $display("[TB] FAIL limit_final_idle: state=%0d expected 0", state);
    end
    checks++;
`else
    if (state !== 4'd7 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nolimit_continue: state=%0d done=%b expected 7/0", state, done);
    end
    checks++;
    tick();
    tick();
    tick();
    tick();
    tick();
    if (state !== 4'd6 || step_count !== 16'd4 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nolimit_fourth: state=%0d steps=%0d done=%b expected 6/4/0", state, step_count, done);
    end
    checks++;
    tick();
    avancar  = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    if (state !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nolimit_halt: state=%0d done=%b expected 0/0", state, done);
    end
    checks++;
`endif
    avancar = 1'b0;
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
    avancar  = 1'b0;
    girar    = 1'b0;
    remover  = 1'b0;
    test_reset();
    test_move_timing();
    test_halt();
    test_clean();
    test_stuck();
    test_reset_mid_clean();
    test_step_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
